bcd_to_bin_seq: RTL and testbench

BCD_TO_BIN_SEQ -- requirements
Module: bcd_to_bin_seq

---
 rtl/bcd_to_bin_seq.sv | 77 +++++++
 tb/tb_bcd_to_bin_seq.sv | 181 ++++++++++++++++++
 2 files changed

// File: rtl/bcd_to_bin_seq.sv
// bcd_to_bin_seq: sequential packed-BCD to binary converter, one digit per clock, MSD first
module bcd_to_bin_seq #(
    parameter int DIGITS = 4,
    parameter int BIN_W  = 14
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [4*DIGITS-1:0]   bcd_in,
    output logic                  busy,
    output logic                  done,
    output logic [BIN_W-1:0]      binary,
    output logic                  err
);
    typedef enum logic [1:0] {IDLE, CONV, DONE} state_t;

    state_t              state;
    logic [4*DIGITS-1:0] sreg;
    logic [BIN_W-1:0]    acc;
    logic [3:0]          idx;
    logic                bad;
    logic [3:0]          digit;
    logic [BIN_W-1:0]    acc_next;
    logic                bad_next;

    // The captured word is shifted left each step, so the current MSD always sits in the top nibble
    always_comb begin
        digit    = sreg[4*DIGITS-1 -: 4];
        acc_next = acc * BIN_W'(10) + BIN_W'(digit);
        bad_next = bad | (digit > 4'd9);
    end

    // Control FSM with registered outputs; binary/err only update on entry to DONE
    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            sreg   <= '0;
            acc    <= '0;
            idx    <= '0;
            bad    <= 1'b0;
            busy   <= 1'b0;
            done   <= 1'b0;
            binary <= '0;
            err    <= 1'b0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    done <= 1'b0;
                    if (start) begin
                        sreg  <= bcd_in;
                        acc   <= '0;
                        bad   <= 1'b0;
                        idx   <= 4'(DIGITS - 1);
                        busy  <= 1'b1;
                        state <= CONV;
                    end else begin
                        state <= IDLE;
                    end
                end
                CONV: begin
                    acc  <= acc_next;
                    bad  <= bad_next;
                    sreg <= sreg << 4;
                    idx  <= idx - 4'd1;
                    if (idx == 4'd0) begin
                        state  <= DONE;
                        busy   <= 1'b0;
                        done   <= 1'b1;
                        binary <= bad_next ? '0 : acc_next;
                        err    <= bad_next;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_bcd_to_bin_seq.sv
// tb_bcd_to_bin_seq: table-driven, hand-sequenced and randomized checks of bcd_to_bin_seq
module tb_bcd_to_bin_seq;
    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [15:0] bcd_in;
    logic        busy;
    logic        done;
    logic [13:0] binary;
    logic        err;

    int n_cmp  = 0;
    int n_fail = 0;
    int prev_bin = 0;
    bit prev_err = 1'b0;

    typedef struct {
        logic [15:0] bcd;
        int          exp_bin;
        bit          exp_err;
    } vec_t;

    vec_t vecs[6];

    always #5 clk = ~clk;

    bcd_to_bin_seq #(.DIGITS(4), .BIN_W(14)) dut (
        .clk    (clk),
        .rst    (rst),
        .start  (start),
        .bcd_in (bcd_in),
        .busy   (busy),
        .done   (done),
        .binary (binary),
        .err    (err)
    );

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Reference: decimal value by plain positional arithmetic; any nibble above 9 flags an error
    function automatic void model(input logic [15:0] b, output int v, output bit e);
        v = 0;
        e = 1'b0;
        for (int i = 3; i >= 0; i--) begin
            int d;
            d = int'((b >> (4 * i)) & 16'hF);
            if (d > 9) e = 1'b1;
            v = v * 10 + d;
        end
        if (e) v = 0;
    endfunction

    // Accept at edge k, scramble bcd_in, check busy/hold for 4 cycles, then the DONE cycle
    task automatic run_conv(input string name, input logic [15:0] b, input int exp_bin, input bit exp_err);
        start  = 1'b1;
        bcd_in = b;
        tick;
        start  = 1'b0;
        bcd_in = 16'($urandom);
        for (int i = 0; i < 4; i++) begin
            chk({name, "_busy"}, 32'(busy), 32'd1);
            chk({name, "_nodone"}, 32'(done), 32'd0);
            chk({name, "_hold"}, 32'(binary), 32'(prev_bin));
            tick;
        end
        chk({name, "_done"}, 32'(done), 32'd1);
        chk({name, "_idle"}, 32'(busy), 32'd0);
        chk({name, "_bin"}, 32'(binary), 32'(exp_bin));
        chk({name, "_err"}, 32'(err), 32'(exp_err));
        prev_bin = exp_bin;
        prev_err = exp_err;
    endtask

    initial begin
        int          v;
        bit          e;
        int          pulses;
        logic [15:0] r;

        vecs[0] = '{16'h1234, 1234, 1'b0};
        vecs[1] = '{16'h0000, 0,    1'b0};
        vecs[2] = '{16'h9999, 9999, 1'b0};
        vecs[3] = '{16'h0001, 1,    1'b0};
        vecs[4] = '{16'h12A4, 0,    1'b1};
        vecs[5] = '{16'h0042, 42,   1'b0};

        rst = 1'b1;
        start = 1'b1;
        bcd_in = 16'h1234;
        tick;
        tick;
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_bin", 32'(binary), 32'd0);
        chk("rst_err", 32'(err), 32'd0);
        rst = 1'b0;
        start = 1'b0;
        tick;

        for (int i = 0; i < 6; i++) begin
            run_conv($sformatf("vec%0d", i), vecs[i].bcd, vecs[i].exp_bin, vecs[i].exp_err);
            tick;
            chk($sformatf("vec%0d_pulse", i), 32'(done), 32'd0);
            chk($sformatf("vec%0d_keep", i), 32'(binary), 32'(prev_bin));
            chk($sformatf("vec%0d_keeperr", i), 32'(err), 32'(prev_err));
        end

        // Start during CONV must be ignored
        start = 1'b1;
        bcd_in = 16'h0500;
        tick;
        start = 1'b0;
        bcd_in = 16'h0777;
        tick;
        start = 1'b1;
        tick;
        start = 1'b0;
        pulses = 0;
        for (int i = 0; i < 8; i++) begin
            if (done) pulses++;
            tick;
        end
        chk("ign_pulses", 32'(pulses), 32'd1);
        chk("ign_bin", 32'(binary), 32'd500);
        chk("ign_busy", 32'(busy), 32'd0);
        prev_bin = 500;
        prev_err = 1'b0;

        // Reset at edge k+2 aborts the conversion
        start = 1'b1;
        bcd_in = 16'h1234;
        tick;
        start = 1'b0;
        tick;
        rst = 1'b1;
        tick;
        rst = 1'b0;
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_bin", 32'(binary), 32'd0);
        pulses = 0;
        for (int i = 0; i < 6; i++) begin
            if (done) pulses++;
            tick;
        end
        chk("abort_pulses", 32'(pulses), 32'd0);
        prev_bin = 0;
        prev_err = 1'b0;
        run_conv("after_rst", 16'h0010, 10, 1'b0);
        tick;

        // Back-to-back: second start accepted in the DONE cycle
        run_conv("b2b_a", 16'h0001, 1, 1'b0);
        run_conv("b2b_b", 16'h0002, 2, 1'b0);
        tick;
        chk("b2b_end", 32'(done), 32'd0);

        // Randomized conversions, occasionally with an out-of-range digit
        for (int n = 0; n < 40; n++) begin
            r = '0;
            for (int d = 0; d < 4; d++)
                r[4*d +: 4] = ($urandom_range(0, 7) == 0) ? 4'($urandom_range(10, 15)) : 4'($urandom_range(0, 9));
            model(r, v, e);
            run_conv($sformatf("rnd%0d", n), r, v, e);
            if ($urandom_range(0, 1) == 1) tick;
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
